// File: rtl/imu_pkg.sv
// Shared types and constants for the IMU sample scheduler.
//   sched_state_t : scheduler FSM states
//   IMU_FRAME_W   : payload width of one IMU burst read
//   SEQ_W         : width of the per-frame sequence number
//   FIFO_W        : width of one buffered entry {seq, payload}
//   sat_inc8      : 8-bit increment that holds at 255
package imu_pkg;

  localparam int unsigned IMU_FRAME_W = 80;
  localparam int unsigned SEQ_W       = 8;
  localparam int unsigned FIFO_W      = IMU_FRAME_W + SEQ_W;

  typedef enum logic [2:0] {
    StIdle,
    StArm,
    StWaitTick,
    StReq,
    StWaitData,
    StFault
  } sched_state_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hff) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/imu_frame_fifo2.sv
// Two-entry FIFO for {seq, frame} entries. All updates are qualified by clk_en.
//   clk, n_rst  : clock, asynchronous active-low reset
//   clk_en      : update qualifier
//   flush       : empty the FIFO (wins over push/pop)
//   push, din   : write request and data; ignored when full unless popping too
//   pop         : remove the head entry
//   full, empty : occupancy flags
//   head        : current head entry; only changes on pop or on a push into an empty FIFO
module imu_frame_fifo2
  import imu_pkg::*;
(
  input  logic              clk,
  input  logic              n_rst,
  input  logic              clk_en,
  input  logic              flush,
  input  logic              push,
  input  logic [FIFO_W-1:0] din,
  input  logic              pop,
  output logic              full,
  output logic              empty,
  output logic [FIFO_W-1:0] head
);

  logic [FIFO_W-1:0] mem0_q, mem0_d, mem1_q, mem1_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              do_pop, do_push;

  always_comb begin
    mem0_d  = mem0_q;
    mem1_d  = mem1_q;
    cnt_d   = cnt_q;
    do_pop  = pop && (cnt_q != 2'd0);
    // A pop in the same cycle frees a slot for a push into a full FIFO.
    do_push = push && ((cnt_q != 2'd2) || do_pop);
    if (flush) begin
      cnt_d = 2'd0;
    end else begin
      if (do_pop) begin
        mem0_d = mem1_q;
        cnt_d  = cnt_q - 2'd1;
      end
      if (do_push) begin
        if (cnt_d == 2'd0) begin
          mem0_d = din;
        end else begin
          mem1_d = din;
        end
        cnt_d = cnt_d + 2'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      mem0_q <= '0;
      mem1_q <= '0;
      cnt_q  <= 2'd0;
    end else if (clk_en) begin
      mem0_q <= mem0_d;
      mem1_q <= mem1_d;
      cnt_q  <= cnt_d;
    end
  end

  assign full  = (cnt_q == 2'd2);
  assign empty = (cnt_q == 2'd0);
  assign head  = mem0_q;

endmodule

// File: rtl/imu_sample_sched.sv
// Sample-rate scheduler and frame handshake controller between the IMU SPI reader
// and the downstream filter. Issues one burst-read request per sample period,
// detects a reader that never answers, buffers returned frames in a 2-entry FIFO
// and reports late ticks and dropped frames.
//   clk, n_rst   : clock, asynchronous active-low reset
//   clk_en       : qualifies every state/counter/FIFO update
//   run          : 1 = schedule samples, 0 = return to idle
//   period       : sample period in qualified cycles (0 treated as 1), latched on start
//   rd_req       : one-cycle burst-read request to the reader
//   rd_valid     : reader data-ready pulse, rd_data sampled with it
//   frame_valid  : FIFO head valid; frame_ready accepts it
//   frame_data   : head payload; frame_seq : head sequence number
//   late_cnt     : ticks seen while a read was outstanding (saturating)
//   drop_cnt     : frames lost to a full FIFO (saturating)
//   fault        : reader timeout, sticky until run drops
module imu_sample_sched
  import imu_pkg::*;
#(
  parameter int unsigned PERIOD_W = 16,
  parameter int unsigned TIMEOUT  = 4095
) (
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic                   clk_en,
  input  logic                   run,
  input  logic [PERIOD_W-1:0]    period,
  output logic                   rd_req,
  input  logic                   rd_valid,
  input  logic [IMU_FRAME_W-1:0] rd_data,
  output logic                   frame_valid,
  input  logic                   frame_ready,
  output logic [IMU_FRAME_W-1:0] frame_data,
  output logic [SEQ_W-1:0]       frame_seq,
  output logic [7:0]             late_cnt,
  output logic [7:0]             drop_cnt,
  output logic                   fault
);

  localparam int unsigned TO_W = $clog2(TIMEOUT + 1);

  sched_state_t        state_q, state_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic [PERIOD_W-1:0] tick_cnt_q, tick_cnt_d;
  logic                tick_q, tick_d;
  logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
  logic [SEQ_W-1:0]    seq_q, seq_d;
  logic [7:0]          late_q, late_d;
  logic [7:0]          drop_q, drop_d;

  logic              push, pop, flush, fifo_full, fifo_empty;
  logic [FIFO_W-1:0] fifo_head;

  assign pop = frame_valid && frame_ready;

  always_comb begin
    state_d    = state_q;
    period_d   = period_q;
    tick_cnt_d = tick_cnt_q;
    tick_d     = 1'b0;
    to_cnt_d   = to_cnt_q;
    seq_d      = seq_q;
    late_d     = late_q;
    drop_d     = drop_q;
    push       = 1'b0;

    // tick_q is high for the one cycle right after the counter wraps.
    if (state_q == StIdle) begin
      tick_cnt_d = '0;
    end else if (tick_cnt_q == period_q - PERIOD_W'(1)) begin
      tick_cnt_d = '0;
      tick_d     = 1'b1;
    end else begin
      tick_cnt_d = tick_cnt_q + PERIOD_W'(1);
    end

    unique case (state_q)
      StIdle: begin
        if (run) begin
          state_d  = StArm;
          period_d = (period == '0) ? PERIOD_W'(1) : period;
        end
      end
      StArm:      state_d = StReq;
      StWaitTick: if (tick_q) state_d = StReq;
      StReq: begin
        state_d  = StWaitData;
        // Counts qualified cycles since the request, so FAULT lands exactly TIMEOUT later.
        to_cnt_d = TO_W'(1);
      end
      StWaitData: begin
        if (rd_valid) begin
          push    = 1'b1;
          seq_d   = seq_q + SEQ_W'(1);
          state_d = StWaitTick;
        end else if (to_cnt_q >= TO_W'(TIMEOUT - 1)) begin
          state_d = StFault;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      StFault: ;
      default: state_d = StIdle;
    endcase

    // A tick during an outstanding read is counted, not queued.
    if (tick_q && ((state_q == StReq) || (state_q == StWaitData))) begin
      late_d = sat_inc8(late_q);
    end
    if (push && fifo_full && !pop) begin
      drop_d = sat_inc8(drop_q);
    end

    if (!run) begin
      state_d    = StIdle;
      push       = 1'b0;
      seq_d      = '0;
      late_d     = 8'd0;
      drop_d     = 8'd0;
      tick_cnt_d = '0;
      tick_d     = 1'b0;
    end
  end

  assign flush = (state_d == StIdle);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= StIdle;
      period_q   <= PERIOD_W'(1);
      tick_cnt_q <= '0;
      tick_q     <= 1'b0;
      to_cnt_q   <= '0;
      seq_q      <= '0;
      late_q     <= 8'd0;
      drop_q     <= 8'd0;
    end else if (clk_en) begin
      state_q    <= state_d;
      period_q   <= period_d;
      tick_cnt_q <= tick_cnt_d;
      tick_q     <= tick_d;
      to_cnt_q   <= to_cnt_d;
      seq_q      <= seq_d;
      late_q     <= late_d;
      drop_q     <= drop_d;
    end
  end

  imu_frame_fifo2 u_fifo (
    .clk    (clk),
    .n_rst  (n_rst),
    .clk_en (clk_en),
    .flush  (flush),
    .push   (push),
    .din    ({seq_q, rd_data}),
    .pop    (pop),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .head   (fifo_head)
  );

  assign rd_req      = (state_q == StReq);
  assign fault       = (state_q == StFault);
  assign frame_valid = !fifo_empty;
  assign frame_data  = fifo_head[IMU_FRAME_W-1:0];
  assign frame_seq   = fifo_head[FIFO_W-1:IMU_FRAME_W];
  assign late_cnt    = late_q;
  assign drop_cnt    = drop_q;

endmodule

// File: tb/tb_imu_sample_sched.sv
// Self-checking bench for imu_sample_sched: a time-indexed behavioural model plus
// directed scenarios with hand-computed literal expectations.
module tb_imu_sample_sched;

  localparam int TMO = 20;

  logic        clk = 1'b0;
  logic        n_rst, clk_en, run, rd_req, rd_valid, frame_valid, frame_ready, fault;
  logic [15:0] period;
  logic [79:0] rd_data, frame_data;
  logic [7:0]  frame_seq, late_cnt, drop_cnt;

  always #5 clk = ~clk;

  imu_sample_sched #(.PERIOD_W(16), .TIMEOUT(TMO)) dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .clk_en      (clk_en),
    .run         (run),
    .period      (period),
    .rd_req      (rd_req),
    .rd_valid    (rd_valid),
    .rd_data     (rd_data),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .frame_data  (frame_data),
    .frame_seq   (frame_seq),
    .late_cnt    (late_cnt),
    .drop_cnt    (drop_cnt),
    .fault       (fault)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 0;

  task automatic chk(input string name, input logic [87:0] got, input logic [87:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Model: m_c = qualified cycles since run was seen (0 = idle, 1 = arm cycle).
  // Ticks fall on cycles c with c >= P+1 and (c-1) % P == 0.
  int          m_c, m_p, m_r;
  bit          m_req, m_out, m_fault;
  logic [7:0]  m_late, m_drop, m_seq;
  logic [87:0] m_q[$];

  task automatic model_idle();
    m_c = 0; m_p = 1; m_r = 0;
    m_req = 0; m_out = 0; m_fault = 0;
    m_late = 8'd0; m_drop = 8'd0; m_seq = 8'd0;
    m_q.delete();
  endtask

  task automatic model_edge();
    bit tick, got, nreq;
    if (!run) begin
      model_idle();
    end else if (m_c == 0) begin
      m_c = 1;
      m_p = (period == 16'd0) ? 1 : int'(period);
      m_req = 0;
    end else begin
      tick = (m_c >= m_p + 1) && (((m_c - 1) % m_p) == 0);
      if (m_q.size() > 0 && frame_ready) void'(m_q.pop_front());
      got = m_out && (m_c > m_r) && rd_valid;
      if (got) begin
        if (m_q.size() < 2) m_q.push_back({m_seq, rd_data});
        else if (m_drop != 8'hff) m_drop++;
        m_seq++;
      end
      if (tick && m_out && m_late != 8'hff) m_late++;
      nreq = (m_c == 1) || (tick && !m_out && !m_fault);
      if (got) m_out = 0;
      else if (m_out && (m_c + 1 - m_r >= TMO)) begin
        m_out = 0;
        m_fault = 1;
      end
      m_c++;
      m_req = nreq;
      if (nreq) begin
        m_out = 1;
        m_r = m_c;
      end
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("rd_req", rd_req, m_req);
      chk("frame_valid", frame_valid, m_q.size() > 0);
      if (m_q.size() > 0) begin
        chk("frame_data", frame_data, m_q[0][79:0]);
        chk("frame_seq", frame_seq, m_q[0][87:80]);
      end
      chk("late_cnt", late_cnt, m_late);
      chk("drop_cnt", drop_cnt, m_drop);
      chk("fault", fault, m_fault);
    end
  end

  // Reader model and cycle bookkeeping (all in qualified cycles).
  int rd_lat, rd_cd, qc, phase;
  bit rd_act, en_div, qe;
  int req_log[$];

  task automatic cyc();
    @(posedge clk);
    qe = clk_en;
    if (clk_en && n_rst) model_edge();
    @(negedge clk);
    if (qe) begin
      qc++;
      if (rd_valid) rd_valid = 1'b0;
      if (rd_act) begin
        rd_cd--;
        if (rd_cd == 0) begin
          rd_valid = 1'b1;
          rd_data  = {$urandom(), $urandom(), 16'($urandom())};
          rd_act   = 0;
        end
      end
      if (rd_req && n_rst) begin
        req_log.push_back(qc);
        if (rd_lat > 0) begin
          rd_act = 1;
          rd_cd  = rd_lat;
        end
      end
    end
    phase  = (phase + 1) % 3;
    clk_en = en_div ? (phase == 0) : 1'b1;
  endtask

  task automatic run_to(input int n);
    int guard = 0;
    while (qc < n && guard < 2000) begin
      cyc();
      guard++;
    end
    if (qc < n) chk("run_to bound", qc, n);
  endtask

  task automatic start(input logic [15:0] p, input int lat);
    period = p;
    rd_lat = lat;
    run    = 1'b1;
    qc     = 0;
    req_log.delete();
  endtask

  task automatic stop();
    run      = 1'b0;
    rd_valid = 1'b0;
    rd_act   = 0;
    repeat (6) cyc();
  endtask

  task automatic chk_reqs(input string name, input int a, input int b, input int c);
    chk({name, " count"}, req_log.size(), 3);
    if (req_log.size() == 3) begin
      chk({name, " req0"}, req_log[0], a);
      chk({name, " req1"}, req_log[1], b);
      chk({name, " req2"}, req_log[2], c);
    end
  endtask

  initial begin
    n_rst = 1'b0; clk_en = 1'b1; run = 1'b0; period = 16'd10;
    rd_valid = 1'b0; rd_data = '0; frame_ready = 1'b1;
    rd_lat = 0; rd_cd = 0; rd_act = 0; qc = 0; phase = 0; en_div = 0;
    model_idle();
    #12;
    chk("reset rd_req", rd_req, 1'b0);
    chk("reset frame_valid", frame_valid, 1'b0);
    chk("reset frame_data", frame_data, 80'd0);
    chk("reset fault", fault, 1'b0);
    @(negedge clk);
    n_rst  = 1'b1;
    chk_en = 1;
    repeat (3) cyc();

    // Nominal: period 10, reader answers after 4 cycles.
    start(16'd10, 4);
    run_to(7);
    chk("s1 first frame valid", frame_valid, 1'b1);
    chk("s1 first frame seq", frame_seq, 8'd0);
    run_to(27);
    chk("s1 third frame seq", frame_seq, 8'd2);
    run_to(30);
    chk_reqs("s1", 2, 12, 22);
    chk("s1 late", late_cnt, 8'd0);
    chk("s1 drop", drop_cnt, 8'd0);
    stop();

    // Backpressure: three responses into a 2-entry FIFO.
    frame_ready = 1'b0;
    start(16'd10, 4);
    run_to(28);
    chk("s2 drop", drop_cnt, 8'd1);
    chk("s2 head seq0", frame_seq, 8'd0);
    frame_ready = 1'b1;
    cyc();
    chk("s2 head seq1", frame_seq, 8'd1);
    run_to(37);
    chk("s2 next seq3 valid", frame_valid, 1'b1);
    chk("s2 next seq3", frame_seq, 8'd3);
    stop();

    // Slow reader: latency 15 > period.
    start(16'd10, 15);
    run_to(60);
    chk_reqs("s3", 2, 22, 42);
    chk("s3 late", late_cnt, 8'd3);
    stop();

    // Reader never answers.
    start(16'd10, 0);
    run_to(21);
    chk("s4 fault before", fault, 1'b0);
    cyc();
    chk("s4 fault at 20", fault, 1'b1);
    run_to(40);
    chk("s4 req count", req_log.size(), 1);
    chk("s4 late", late_cnt, 8'd2);
    run = 1'b0;
    cyc();
    chk("s4 fault cleared", fault, 1'b0);
    cyc();
    start(16'd10, 4);
    run_to(7);
    chk("s4 restart valid", frame_valid, 1'b1);
    chk("s4 restart seq", frame_seq, 8'd0);
    stop();

    // clk_en 1-in-3.
    en_div = 1;
    start(16'd10, 4);
    run_to(30);
    chk_reqs("s5", 2, 12, 22);
    stop();
    en_div = 0;
    repeat (3) cyc();

    // Asynchronous reset during WAIT_DATA.
    frame_ready = 1'b0;
    start(16'd10, 4);
    run_to(13);
    chk("s6 frame held", frame_valid, 1'b1);
    chk_en = 0;
    #2;
    n_rst = 1'b0;
    run   = 1'b0;
    model_idle();
    #1;
    chk("s6 rst rd_req", rd_req, 1'b0);
    chk("s6 rst frame_valid", frame_valid, 1'b0);
    chk("s6 rst frame_data", frame_data, 80'd0);
    chk("s6 rst frame_seq", frame_seq, 8'd0);
    chk("s6 rst late", late_cnt, 8'd0);
    chk("s6 rst drop", drop_cnt, 8'd0);
    chk("s6 rst fault", fault, 1'b0);
    cyc();
    n_rst  = 1'b1;
    chk_en = 1;
    run_to(20);
    chk("s6 late rd_valid ignored", frame_valid, 1'b0);
    frame_ready = 1'b1;
    repeat (3) cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
